// File: rtl/fp_align_add_serial_if.sv
// fp_align_add_serial_if: operand/result bundle for the alignment + add stage.
//   master: drives Load and the unpacked operands (S_x, E_x, M_x), observes status/result.
//   slave : the stage itself; observes operands, drives Busy, Done and the result fields
//           (S_Result, E_Result, M_Result, GRS, Carry).
interface fp_align_add_serial_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24
);
    logic             Load;
    logic             S_A;
    logic             S_B;
    logic [EXP_W-1:0] E_A;
    logic [EXP_W-1:0] E_B;
    logic [MAN_W-1:0] M_A;
    logic [MAN_W-1:0] M_B;
    logic             Busy;
    logic             Done;
    logic             S_Result;
    logic [EXP_W-1:0] E_Result;
    logic [MAN_W-1:0] M_Result;
    logic [2:0]       GRS;
    logic             Carry;

    modport master (
        output Load, S_A, S_B, E_A, E_B, M_A, M_B,
        input  Busy, Done, S_Result, E_Result, M_Result, GRS, Carry
    );

    modport slave (
        input  Load, S_A, S_B, E_A, E_B, M_A, M_B,
        output Busy, Done, S_Result, E_Result, M_Result, GRS, Carry
    );
endinterface

// File: rtl/fp_align_add_serial.sv
// fp_align_add_serial: mantissa alignment and signed-magnitude adder stage of the FP adder.
// Operands are swapped so X has the larger magnitude, Y's mantissa is right-shifted by the
// clamped exponent difference into a {mantissa, G, R, S} working register, then X +/- Y is
// formed. The result is unnormalised and goes on to the normaliser/rounder.
//
// Ports:
//   Clk   - clock, rising edge
//   Reset - asynchronous active-low reset
//   bus   - fp_align_add_serial_if.slave: Load + operands in; Busy, Done, result out
//
// Build option: define FAST_ALIGN_EN for a single-cycle barrel-shift ALIGN (fixed latency).
// Without it, Y shifts one bit per cycle (latency = shift count + 2). Results are identical.
module fp_align_add_serial #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24
) (
    input logic                 Clk,
    input logic                 Reset,
    fp_align_add_serial_if.slave bus
);

    localparam int unsigned W     = MAN_W + 3;
    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {StIdle, StAlign, StAdd, StDone} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic             sx_q, sx_d;
    logic             sy_q, sy_d;
    logic [EXP_W-1:0] ex_q, ex_d;
    logic [CNT_W-1:0] dc_q, dc_d;

    logic             s_res_q, s_res_d;
    logic [EXP_W-1:0] e_res_q, e_res_d;
    logic [MAN_W-1:0] m_res_q, m_res_d;
    logic [2:0]       grs_q, grs_d;
    logic             carry_q, carry_d;

    // Operand ordering: larger exponent wins, then larger mantissa, ties go to A.
    logic             a_is_x;
    logic [EXP_W-1:0] exp_diff;
    logic [CNT_W-1:0] dc_load;

    always_comb begin
        a_is_x   = (bus.E_A > bus.E_B) || ((bus.E_A == bus.E_B) && (bus.M_A >= bus.M_B));
        exp_diff = a_is_x ? (bus.E_A - bus.E_B) : (bus.E_B - bus.E_A);
        // Beyond W shifts every Y bit is already in sticky, so clamp the count.
        if (int'(exp_diff) > int'(W)) begin
            dc_load = CNT_W'(W);
        end else begin
            dc_load = CNT_W'(exp_diff);
        end
    end

`ifdef FAST_ALIGN_EN
    // Barrel shift by the whole count; sticky collects every bit pushed below bit 0.
    // For dc_q == W the mask wraps to all ones, which is exactly what is wanted.
    logic [W-1:0] y_shift;
    logic [W-1:0] lost_mask;
    logic [W-1:0] y_aligned;

    always_comb begin
        y_shift   = y_q >> dc_q;
        lost_mask = (W'(1) << dc_q) - W'(1);
        y_aligned = {y_shift[W-1:1], y_shift[0] | (|(y_q & lost_mask))};
    end
`else
    // One-bit step: R falls into sticky, sticky never clears.
    logic [W-1:0] y_step;

    always_comb begin
        y_step = {1'b0, y_q[W-1:2], y_q[1] | y_q[0]};
    end
`endif

    // Swap guarantees X >= Y, so the subtract path never goes negative.
    logic         same_sign;
    logic [W:0]   sum_w;

    always_comb begin
        same_sign = (sx_q == sy_q);
        if (same_sign) begin
            sum_w = {1'b0, x_q} + {1'b0, y_q};
        end else begin
            sum_w = {1'b0, x_q} - {1'b0, y_q};
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ex_d    = ex_q;
        dc_d    = dc_q;
        s_res_d = s_res_q;
        e_res_d = e_res_q;
        m_res_d = m_res_q;
        grs_d   = grs_q;
        carry_d = carry_q;

        unique case (state_q)
            StIdle: begin
                if (bus.Load) begin
                    if (a_is_x) begin
                        x_d  = {bus.M_A, 3'b000};
                        y_d  = {bus.M_B, 3'b000};
                        sx_d = bus.S_A;
                        sy_d = bus.S_B;
                        ex_d = bus.E_A;
                    end else begin
                        x_d  = {bus.M_B, 3'b000};
                        y_d  = {bus.M_A, 3'b000};
                        sx_d = bus.S_B;
                        sy_d = bus.S_A;
                        ex_d = bus.E_B;
                    end
                    dc_d    = dc_load;
                    state_d = StAlign;
                end
            end
            StAlign: begin
`ifdef FAST_ALIGN_EN
                y_d     = y_aligned;
                dc_d    = '0;
                state_d = StAdd;
`else
                if (dc_q == '0) begin
                    state_d = StAdd;
                end else begin
                    y_d  = y_step;
                    dc_d = dc_q - CNT_W'(1);
                end
`endif
            end
            StAdd: begin
                m_res_d = sum_w[W-1:3];
                grs_d   = sum_w[2:0];
                carry_d = same_sign & sum_w[W];
                s_res_d = sx_q;
                e_res_d = ex_q;
                // Exact cancellation yields +0.
                if (!same_sign && (sum_w == '0)) begin
                    s_res_d = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            ex_q    <= '0;
            dc_q    <= '0;
            s_res_q <= 1'b0;
            e_res_q <= '0;
            m_res_q <= '0;
            grs_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ex_q    <= ex_d;
            dc_q    <= dc_d;
            s_res_q <= s_res_d;
            e_res_q <= e_res_d;
            m_res_q <= m_res_d;
            grs_q   <= grs_d;
            carry_q <= carry_d;
        end
    end

    assign bus.Busy     = (state_q != StIdle);
    assign bus.Done     = (state_q == StDone);
    assign bus.S_Result = s_res_q;
    assign bus.E_Result = e_res_q;
    assign bus.M_Result = m_res_q;
    assign bus.GRS      = grs_q;
    assign bus.Carry    = carry_q;

endmodule

// File: tb/tb_fp_align_add_serial.sv
// Self-checking bench for fp_align_add_serial (EXP_W=8, MAN_W=24): directed plan cases,
// randomized operands against an arithmetic reference model, reset abort, ignored Load
// while busy and Load held high across two operations.
module tb_fp_align_add_serial;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
`ifdef FAST_ALIGN_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    fp_align_add_serial_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_align_add_serial #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;

    // Observed results of the last operation.
    logic        r_s, r_c, r_pd, r_pb;
    logic [7:0]  r_e;
    logic [23:0] r_m;
    logic [2:0]  r_grs;
    int          r_lat;

    // Model expectations.
    logic        x_s, x_c;
    logic [7:0]  x_e;
    logic [23:0] x_m;
    logic [2:0]  x_grs;
    int          x_lat;

    // Reference: exact integer arithmetic on the value mantissa*8 (three extra low bits),
    // Y divided by 2^d with any nonzero remainder folded into the lowest bit.
    task automatic model(input logic sa, input logic sb, input logic [7:0] ea,
                         input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb);
        logic                  a_big, sx, sy;
        int                    ex, ey, d;
        longint unsigned       xw, yw, pw, rem, r;
        a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
        sx = a_big ? sa : sb;
        sy = a_big ? sb : sa;
        ex = a_big ? int'(ea) : int'(eb);
        ey = a_big ? int'(eb) : int'(ea);
        xw = 64'(a_big ? ma : mb) * 8;
        yw = 64'(a_big ? mb : ma) * 8;
        d  = ex - ey;
        if (d > 27) d = 27;
        pw  = 64'd1 << d;
        rem = yw % pw;
        yw  = yw / pw;
        if (rem != 0) yw = yw | 64'd1;
        r     = (sx == sy) ? (xw + yw) : (xw - yw);
        x_c   = (sx == sy) && (r >= 64'd134217728);
        x_m   = 24'((r / 8) % 64'd16777216);
        x_grs = 3'(r % 8);
        x_s   = ((sx != sy) && (r == 0)) ? 1'b0 : sx;
        x_e   = 8'(ex);
        x_lat = FAST ? 2 : d + 2;
    endtask

    task automatic drive_ops(input logic sa, input logic sb, input logic [7:0] ea,
                             input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb);
        bus.S_A = sa;
        bus.S_B = sb;
        bus.E_A = ea;
        bus.E_B = eb;
        bus.M_A = ma;
        bus.M_B = mb;
    endtask

    // Accept at edge 0, count edges to Done (bounded), capture, then one more edge.
    task automatic run_op(input logic sa, input logic sb, input logic [7:0] ea,
                          input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb);
        @(negedge Clk);
        drive_ops(sa, sb, ea, eb, ma, mb);
        bus.Load = 1'b1;
        @(posedge Clk);
        #1 bus.Load = 1'b0;
        r_lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) begin
                r_lat = i;
                break;
            end
        end
        r_s   = bus.S_Result;
        r_e   = bus.E_Result;
        r_m   = bus.M_Result;
        r_grs = bus.GRS;
        r_c   = bus.Carry;
        @(posedge Clk);
        #1;
        r_pd = bus.Done;
        r_pb = bus.Busy;
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        bus.Load = 1'b0;
        drive_ops(1'b0, 1'b0, 8'd0, 8'd0, 24'd0, 24'd0);
        #1 Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus.Busy !== 1'b0) $display("FAIL reset Busy: got %b want 0", bus.Busy);
        else passes++;
        checks++;
        if (bus.Done !== 1'b0) $display("FAIL reset Done: got %b want 0", bus.Done);
        else passes++;
        checks++;
        if ({bus.S_Result, bus.E_Result, bus.M_Result, bus.GRS, bus.Carry} !== 37'd0)
            $display("FAIL reset outputs: got %h/%h/%h/%b/%b want all 0", bus.S_Result,
                     bus.E_Result, bus.M_Result, bus.GRS, bus.Carry);
        else passes++;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_directed();
        logic        t_sa  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        t_sb  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0]  t_ea  [5] = '{8'd130, 8'd130, 8'd120, 8'd120, 8'd100};
        logic [7:0]  t_eb  [5] = '{8'd120, 8'd120, 8'd120, 8'd120, 8'd200};
        logic [23:0] t_ma  [5] = '{24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'hC00001};
        logic [23:0] t_m   [5] = '{24'h802000, 24'h7FE000, 24'h000000, 24'h000000, 24'h800000};
        logic [2:0]  t_grs [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        logic        t_c   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        t_s   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  t_e   [5] = '{8'd130, 8'd130, 8'd120, 8'd120, 8'd200};
        int          t_lat [5] = '{12, 12, 2, 2, 29};
        int          want_lat;
        for (int k = 0; k < 5; k++) begin
            run_op(t_sa[k], t_sb[k], t_ea[k], t_eb[k], t_ma[k], 24'h800000);
            want_lat = FAST ? 2 : t_lat[k];
            checks++;
            if (r_lat !== want_lat)
                $display("FAIL plan%0d latency: got %0d want %0d", k + 1, r_lat, want_lat);
            else passes++;
            checks++;
            if (r_m !== t_m[k])
                $display("FAIL plan%0d M_Result: got %h want %h", k + 1, r_m, t_m[k]);
            else passes++;
            checks++;
            if (r_grs !== t_grs[k])
                $display("FAIL plan%0d GRS: got %b want %b", k + 1, r_grs, t_grs[k]);
            else passes++;
            checks++;
            if (r_c !== t_c[k]) $display("FAIL plan%0d Carry: got %b want %b", k + 1, r_c, t_c[k]);
            else passes++;
            checks++;
            if (r_s !== t_s[k])
                $display("FAIL plan%0d S_Result: got %b want %b", k + 1, r_s, t_s[k]);
            else passes++;
            checks++;
            if (r_e !== t_e[k])
                $display("FAIL plan%0d E_Result: got %0d want %0d", k + 1, r_e, t_e[k]);
            else passes++;
            checks++;
            if ({r_pd, r_pb} !== 2'b00)
                $display("FAIL plan%0d after Done: got Done/Busy %b%b want 00", k + 1, r_pd, r_pb);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic        sa, sb;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        int          e2;
        for (int k = 0; k < 40; k++) begin
            sa = 1'($urandom);
            sb = 1'($urandom);
            ea = 8'($urandom_range(254, 1));
            case ($urandom_range(2, 0))
                0: e2 = int'(ea);
                1: e2 = int'(ea) + int'($urandom_range(30, 0)) - 15;
                default: e2 = int'($urandom_range(254, 1));
            endcase
            if (e2 < 1) e2 = 1;
            if (e2 > 254) e2 = 254;
            eb = 8'(e2);
            ma = {1'b1, 23'($urandom)};
            mb = ($urandom_range(3, 0) == 0) ? ma : {1'b1, 23'($urandom)};
            model(sa, sb, ea, eb, ma, mb);
            run_op(sa, sb, ea, eb, ma, mb);
            checks++;
            if (r_lat !== x_lat) $display("FAIL rnd%0d latency: got %0d want %0d", k, r_lat, x_lat);
            else passes++;
            checks++;
            if (r_m !== x_m) $display("FAIL rnd%0d M_Result: got %h want %h", k, r_m, x_m);
            else passes++;
            checks++;
            if (r_grs !== x_grs) $display("FAIL rnd%0d GRS: got %b want %b", k, r_grs, x_grs);
            else passes++;
            checks++;
            if (r_c !== x_c) $display("FAIL rnd%0d Carry: got %b want %b", k, r_c, x_c);
            else passes++;
            checks++;
            if (r_s !== x_s) $display("FAIL rnd%0d S_Result: got %b want %b", k, r_s, x_s);
            else passes++;
            checks++;
            if (r_e !== x_e) $display("FAIL rnd%0d E_Result: got %0d want %0d", k, r_e, x_e);
            else passes++;
            checks++;
            if ({r_pd, r_pb} !== 2'b00)
                $display("FAIL rnd%0d after Done: got Done/Busy %b%b want 00", k, r_pd, r_pb);
            else passes++;
        end
    endtask

    task automatic test_reset_abort();
        logic seen_done;
        @(negedge Clk);
        drive_ops(1'b0, 1'b0, 8'd130, 8'd120, 24'h800000, 24'h800000);
        bus.Load = 1'b1;
        @(posedge Clk);
        #1 bus.Load = 1'b0;
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({bus.Busy, bus.Done} !== 2'b00)
            $display("FAIL abort Busy/Done: got %b%b want 00", bus.Busy, bus.Done);
        else passes++;
        checks++;
        if ({bus.S_Result, bus.E_Result, bus.M_Result, bus.GRS, bus.Carry} !== 37'd0)
            $display("FAIL abort outputs: got %h/%h/%h/%b/%b want all 0", bus.S_Result,
                     bus.E_Result, bus.M_Result, bus.GRS, bus.Carry);
        else passes++;
        @(negedge Clk);
        Reset     = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (bus.Done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) $display("FAIL abort late Done: got %b want 0", seen_done);
        else passes++;
        checks++;
        if (bus.Busy !== 1'b0) $display("FAIL abort idle Busy: got %b want 0", bus.Busy);
        else passes++;
    endtask

    task automatic test_load_ignored();
        model(1'b0, 1'b0, 8'd130, 8'd120, 24'h800000, 24'h800000);
        @(negedge Clk);
        drive_ops(1'b0, 1'b0, 8'd130, 8'd120, 24'h800000, 24'h800000);
        bus.Load = 1'b1;
        @(posedge Clk);
        #1 bus.Load = 1'b0;
        r_lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 3) begin
                @(negedge Clk);
                drive_ops(1'b1, 1'b1, 8'd120, 8'd120, 24'h800000, 24'h800000);
                bus.Load = 1'b1;
                checks++;
                if (bus.Busy !== 1'b1) $display("FAIL ignore Busy mid-op: got %b want 1", bus.Busy);
                else passes++;
            end
            @(posedge Clk);
            #1 bus.Load = 1'b0;
            if (bus.Done) begin
                r_lat = i;
                break;
            end
        end
        checks++;
        if (r_lat !== x_lat) $display("FAIL ignore latency: got %0d want %0d", r_lat, x_lat);
        else passes++;
        checks++;
        if ({bus.M_Result, bus.GRS, bus.Carry, bus.S_Result, bus.E_Result} !==
            {x_m, x_grs, x_c, x_s, x_e})
            $display("FAIL ignore result: got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d",
                     bus.M_Result, bus.GRS, bus.Carry, bus.S_Result, bus.E_Result,
                     x_m, x_grs, x_c, x_s, x_e);
        else passes++;
        repeat (4) @(posedge Clk);
        #1;
        checks++;
        if (bus.Busy !== 1'b0) $display("FAIL ignore restart: got Busy %b want 0", bus.Busy);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic        s1a, s1b, s2a, s2b;
        logic [7:0]  e1a, e1b, e2a, e2b;
        logic [23:0] m1a, m1b, m2a, m2b;
        logic [40:0] want1, want2, got1;
        int          lat1, lat2, first_at, second_at;
        s1a = 1'($urandom); s1b = 1'($urandom); e1a = 8'd90; e1b = 8'd97;
        m1a = {1'b1, 23'($urandom)}; m1b = {1'b1, 23'($urandom)};
        s2a = 1'($urandom); s2b = ~s2a; e2a = 8'd60; e2b = 8'd55;
        m2a = {1'b1, 23'($urandom)}; m2b = {1'b1, 23'($urandom)};
        model(s1a, s1b, e1a, e1b, m1a, m1b);
        want1 = {x_m, x_grs, x_c, x_s, x_e, 1'b0};
        lat1  = x_lat;
        model(s2a, s2b, e2a, e2b, m2a, m2b);
        want2 = {x_m, x_grs, x_c, x_s, x_e, 1'b0};
        lat2  = x_lat;
        @(negedge Clk);
        drive_ops(s1a, s1b, e1a, e1b, m1a, m1b);
        bus.Load = 1'b1;
        @(posedge Clk);
        #1 drive_ops(s2a, s2b, e2a, e2b, m2a, m2b);
        first_at  = -1;
        second_at = -1;
        got1      = '0;
        for (int i = 1; i <= 150; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) begin
                if (first_at < 0) begin
                    first_at = i;
                    got1 = {bus.M_Result, bus.GRS, bus.Carry, bus.S_Result, bus.E_Result, 1'b0};
                end else begin
                    second_at = i;
                    bus.Load  = 1'b0;
                    break;
                end
            end
        end
        bus.Load = 1'b0;
        checks++;
        if (first_at !== lat1) $display("FAIL b2b first Done: got %0d want %0d", first_at, lat1);
        else passes++;
        checks++;
        if (got1 !== want1) $display("FAIL b2b first result: got %h want %h", got1, want1);
        else passes++;
        checks++;
        if (second_at !== lat1 + 2 + lat2)
            $display("FAIL b2b second Done: got %0d want %0d", second_at, lat1 + 2 + lat2);
        else passes++;
        checks++;
        if ({bus.M_Result, bus.GRS, bus.Carry, bus.S_Result, bus.E_Result, 1'b0} !== want2)
            $display("FAIL b2b second result: got %h want %h",
                     {bus.M_Result, bus.GRS, bus.Carry, bus.S_Result, bus.E_Result, 1'b0}, want2);
        else passes++;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus.Busy !== 1'b0) $display("FAIL b2b idle Busy: got %b want 0", bus.Busy);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_load_ignored();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fp_align_add_serial.md
Name: fp_align_add_serial

Overview:
- Parametrised successor to the fixed 8/24-bit mantissa alignment and adder stage of the floating-point adder.
- Accepts two unpacked operands (sign, biased exponent, mantissa with explicit hidden bit) and swaps them so that X has the larger magnitude.
- Right-shifts the smaller operand's mantissa one bit per cycle, using guard/round/sticky tracking and a clamped shift count.
- Then performs a signed-magnitude add or subtract. Output is unnormalised and feeds the normaliser/rounder stage.

Parameters:
- EXP_W, 8, exponent width in bits.
- MAN_W, 24, mantissa width including hidden bit.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Load  input  1  operand strobe; accepted only when Busy=0.
- S_A  input  1  sign of A.
- S_B  input  1  sign of B.
- E_A  input  EXP_W  exponent of A.
- E_B  input  EXP_W  exponent of B.
- M_A  input  MAN_W  mantissa of A.
- M_B  input  MAN_W  mantissa of B.
- Busy  output  1  high from accept until return to IDLE.
- Done  output  1  one-cycle pulse; result valid.
- S_Result  output  1  result sign.
- E_Result  output  EXP_W  larger exponent, unnormalised.
- M_Result  output  MAN_W  result mantissa, top MAN_W bits of working sum.
- GRS  output  3  guard, round, sticky bits of the result.
- Carry  output  1  carry-out of the magnitude addition.

Behaviour:
- Reset low, asynchronous: state=IDLE; Busy, Done, S_Result, E_Result, M_Result, GRS and Carry all 0. Reset mid-operation aborts the operation, and the abandoned operation produces no Done.
- Working width W = MAN_W+3, formed as {mantissa, G, R, S}.
- IDLE: Load=1 at an edge captures the operands.
  - X is the operand with the larger exponent. On equal exponents, X has the larger mantissa. On full equality, X=A.
  - Y is the other operand.
  - Count Dc = min(E_X−E_Y, MAN_W+3).
  - Next state ALIGN, Busy=1.
- ALIGN:
  - If Dc=0, go to ADD.
  - Otherwise, shift Y's working register right by 1, with S_new = S_old | R_old, and decrement Dc.
  - A clamped shift drains every Y bit into sticky.
- ADD, one cycle, registers all outputs:
  - If S_X==S_Y: sum = X + Y over W bits, Carry = bit W, S_Result = S_X.
  - Otherwise: diff = X − Y, which is never negative because of the swap. Carry=0, S_Result=S_X.
  - If diff==0: S_Result=0, M_Result=0, GRS=0.
  - E_Result = E_X in all cases.
  - Next state DONE.
- DONE: Done=1 for this cycle only, Busy=0 on exit, return to IDLE.
- Latency: the Load-accept edge is edge 0. Done is high in the cycle after edge Dc+2, so the minimum latency is 2 cycles at equal exponents.
- Load while Busy=1 is ignored and has no side effect. Load held high continuously re-triggers on the first IDLE cycle.
- Result outputs hold their value until the next ADD cycle.
- No handling of exponent all-ones or denormals; the upstream unpacker owns those cases.

Optional Feature:
- Macro FAST_ALIGN_EN.
- Defined: ALIGN is a single cycle. A barrel shifter shifts by Dc, with sticky = OR of all shifted-out bits. Latency is a fixed 3 edges, so Done is high in the cycle after edge 2 for every input.
- Undefined: serial shifting as described in Behaviour, with latency Dc+2.
- Results are bit-identical in both modes.

Test Plan (EXP_W=8, MAN_W=24):
1. S_A=0, S_B=0, E_A=130, E_B=120, M_A=M_B=0x800000 -> Done after edge 12; M_Result=0x802000, GRS=000, Carry=0, S_Result=0, E_Result=130.
2. Same as scenario 1 but S_A=1 -> M_Result=0x7FE000, S_Result=1, E_Result=130, Carry=0.
3. S_A=1, S_B=0, E_A=E_B=120, M_A=M_B=0x800000 -> Done after edge 2; M_Result=0, GRS=0, S_Result=0, Carry=0.
4. S_A=S_B=1, E_A=E_B=120, M_A=M_B=0x800000 -> M_Result=0x000000, Carry=1, S_Result=1, E_Result=120.
5. E_A=100, E_B=200, M_A=0xC00001, M_B=0x800000, signs 0 -> Dc clamps to 27 and Done arrives after edge 29; swap applies, giving M_Result=0x800000, GRS=001, E_Result=200.
6. Reset low during ALIGN of scenario 1 -> Busy, Done and outputs go to 0 immediately, with no later Done. Separately, a Load pulse at edge 3 of a running operation is ignored and the first result is unchanged.
